// File: rtl/cla_serial_adder_2bit_if.sv
// cla_serial_adder_2bit_if: start/done handshake and operand/result bus of the serial adder
interface cla_serial_adder_2bit_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  modport master (output start, a, b, cin, input busy, done, sum, cout, overflow);
  modport slave (input start, a, b, cin, output busy, done, sum, cout, overflow);
endinterface

// File: rtl/cla_serial_adder_2bit.sv
// cla_serial_adder_2bit: digit-serial adder, one 2-bit carry-lookahead slice per clock
module cla_serial_adder_2bit #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  cla_serial_adder_2bit_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       p, g, s;
  logic             c0, c1, last, accept;
  always_comb begin
    p       = a_q[1:0] ^ b_q[1:0];
    g       = a_q[1:0] & b_q[1:0];
    c0      = g[0] | (p[0] & carry_q);
    c1      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    s       = p ^ {c0, carry_q};
    last    = cnt_q == CW'(N - 1);
    accept  = bus.start && state_q != RUN;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      // slice sums enter at the MSB end so the LSB slice lands at bit 0 after N steps
      r_d     = (r_q >> 2) | (WIDTH'(s) << (WIDTH - 2));
      a_d     = a_q >> 2;
      b_d     = b_q >> 2;
      carry_d = c1;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        sum_d   = r_d;
        cout_d  = c1;
        ovf_d   = c1 ^ c0;
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.busy     = state_q == RUN;
  assign bus.done     = state_q == DONE;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule
